max7219_ctrlmod: RTL and testbench

- Command sequencer directly upstream of the MAX7219 serial write function module.
- After reset it issues the MAX7219 initialisation writes. It then pushes an 8-digit frame, one 16-bit command per call, using the write module's call/done handshake.
- Frames are sent on demand (iUpdate) or on a periodic refresh tick. Intensity changes are forwarded automatically.

---
 rtl/max7219_pkg.sv | 24 ++
 rtl/max7219_initrom.sv | 28 ++
 rtl/max7219_ctrlmod.sv | 211 +++++++++++++++++++++
 tb/tb_max7219_ctrlmod.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 command sequencer: register map,
// sequencer states and init table size.
package max7219_pkg;

    localparam logic [7:0] REG_NOOP      = 8'h00;
    localparam logic [7:0] REG_DIGIT0    = 8'h01;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCANLIM   = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    localparam int unsigned INIT_CMD_CNT = 6;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_LOAD,
        ST_WAIT,
        ST_GAP,
        ST_IDLE,
        ST_FRAME
    } state_e;

endpackage

// File: rtl/max7219_initrom.sv
// Power-up command table for the MAX7219: index -> {register address, data}.
module max7219_initrom
    import max7219_pkg::*;
#(
    parameter logic [7:0] DECODE_MODE = 8'h00,
    parameter logic [7:0] SCAN_LIMIT  = 8'h07
) (
    input  logic [2:0] idx,
    input  logic [3:0] intensity,
    output logic [7:0] addr,
    output logic [7:0] data
);

    always_comb begin
        addr = REG_NOOP;
        data = '0;
        case (idx)
            3'd0: begin addr = REG_TEST;      data = 8'h00;             end
            3'd1: begin addr = REG_SHUTDOWN;  data = 8'h00;             end
            3'd2: begin addr = REG_SCANLIM;   data = SCAN_LIMIT;        end
            3'd3: begin addr = REG_DECODE;    data = DECODE_MODE;       end
            3'd4: begin addr = REG_INTENSITY; data = {4'h0, intensity}; end
            3'd5: begin addr = REG_SHUTDOWN;  data = 8'h01;             end
            default: begin addr = REG_NOOP;   data = 8'h00;             end
        endcase
    end

endmodule

// File: rtl/max7219_ctrlmod.sv
// MAX7219 command sequencer: runs the init table, then pushes 8-digit frames
// (plus intensity updates) to the serial write module via call/done.
module max7219_ctrlmod
    import max7219_pkg::*;
#(
    parameter int unsigned REFRESH_CYC = 5_000_000,
    parameter logic [7:0]  DECODE_MODE = 8'h00,
    parameter logic [7:0]  SCAN_LIMIT  = 8'h07,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        CLOCK,
    input  logic        RST,
    input  logic [63:0] iDIGITS,
    input  logic [3:0]  iIntensity,
    input  logic        iUpdate,
    output logic        oCall,
    output logic [7:0]  oADDR,
    output logic [7:0]  oDATA,
    input  logic        iDone,
    output logic        oBusy,
    output logic        oInitDone,
    output logic        oTimeout
);

    state_e      state_q,     state_d;
    logic [2:0]  init_idx_q,  init_idx_d;
    logic [3:0]  frame_idx_q, frame_idx_d;
    logic [7:0]  addr_q,      addr_d;
    logic [7:0]  data_q,      data_d;
    logic        call_q,      call_d;
    logic        busy_q,      busy_d;
    logic        init_done_q, init_done_d;
    logic        timeout_q,   timeout_d;
    logic        pend_q,      pend_d;
    logic [31:0] refresh_q,   refresh_d;
    logic [3:0]  shadow_q,    shadow_d;
    logic [63:0] snap_q,      snap_d;
    logic [31:0] wdog_q,      wdog_d;
    logic [3:0]  gap_q,       gap_d;

    logic        tick;
    logic [3:0]  digit;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;

    max7219_initrom #(
        .DECODE_MODE (DECODE_MODE),
        .SCAN_LIMIT  (SCAN_LIMIT)
    ) u_initrom (
        .idx       (init_idx_q),
        .intensity (iIntensity),
        .addr      (rom_addr),
        .data      (rom_data)
    );

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        frame_idx_d = frame_idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        call_d      = call_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        timeout_d   = 1'b0;
        pend_d      = pend_q;
        refresh_d   = refresh_q;
        shadow_d    = shadow_q;
        snap_d      = snap_q;
        wdog_d      = wdog_q;
        gap_d       = gap_q;
        tick        = 1'b0;
        digit       = '0;

        if (init_done_q && (REFRESH_CYC != 0)) begin
            if (refresh_q == 32'(REFRESH_CYC - 1)) begin
                refresh_d = '0;
                tick      = 1'b1;
            end else begin
                refresh_d = refresh_q + 32'd1;
            end
        end

        if (iUpdate || tick) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_INIT: begin
                addr_d     = rom_addr;
                data_d     = rom_data;
                if (rom_addr == REG_INTENSITY) begin
                    shadow_d = iIntensity;
                end
                init_idx_d = init_idx_q + 3'd1;
                state_d    = ST_LOAD;
            end
            ST_LOAD: begin
                call_d  = 1'b1;
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (iDone) begin
                    call_d  = 1'b0;
                    gap_d   = 4'(GAP_CYC - 1);
                    state_d = ST_GAP;
                end else if (wdog_q == TIMEOUT_CYC - 1) begin
                    call_d    = 1'b0;
                    timeout_d = 1'b1;
                    gap_d     = 4'(GAP_CYC - 1);
                    state_d   = ST_GAP;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            ST_GAP: begin
                // The init sequence hands over straight to a forced frame.
                if (gap_q != '0) begin
                    gap_d = gap_q - 4'd1;
                end else if (!init_done_q) begin
                    if (init_idx_q == 3'(INIT_CMD_CNT)) begin
                        init_done_d = 1'b1;
                        snap_d      = iDIGITS;
                        frame_idx_d = '0;
                        state_d     = ST_FRAME;
                    end else begin
                        state_d = ST_INIT;
                    end
                end else if (frame_idx_q == 4'd9) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FRAME;
                end
            end
            ST_IDLE: begin
                if (pend_q) begin
                    pend_d      = iUpdate | tick;
                    busy_d      = 1'b1;
                    snap_d      = iDIGITS;
                    frame_idx_d = '0;
                    state_d     = ST_FRAME;
                end
            end
            ST_FRAME: begin
                // Index 0 is the optional intensity write; 1..8 are digit addresses.
                if ((frame_idx_q == '0) && (iIntensity != shadow_q)) begin
                    addr_d      = REG_INTENSITY;
                    data_d      = {4'h0, iIntensity};
                    shadow_d    = iIntensity;
                    frame_idx_d = 4'd1;
                end else begin
                    digit       = (frame_idx_q == '0) ? 4'd1 : frame_idx_q;
                    addr_d      = REG_DIGIT0 + {4'h0, digit - 4'd1};
                    data_d      = snap_q[{digit[2:0] - 3'd1, 3'b000} +: 8];
                    frame_idx_d = digit + 4'd1;
                end
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            frame_idx_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            call_q      <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            pend_q      <= 1'b0;
            refresh_q   <= '0;
            shadow_q    <= '0;
            snap_q      <= '0;
            wdog_q      <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            frame_idx_q <= frame_idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            call_q      <= call_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            timeout_q   <= timeout_d;
            pend_q      <= pend_d;
            refresh_q   <= refresh_d;
            shadow_q    <= shadow_d;
            snap_q      <= snap_d;
            wdog_q      <= wdog_d;
            gap_q       <= gap_d;
        end
    end

    assign oCall     = call_q;
    assign oADDR     = addr_q;
    assign oDATA     = data_q;
    assign oBusy     = busy_q;
    assign oInitDone = init_done_q;
    assign oTimeout  = timeout_q;

endmodule

// File: tb/tb_max7219_ctrlmod.sv
// Directed bench for max7219_ctrlmod: dut_a (no auto refresh) exercises the
// sequencing features, dut_b (1000-cycle refresh) runs untouched after init.
`timescale 1ns/1ps
module tb_max7219_ctrlmod;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst, rst_b;
    logic [63:0] digits;
    logic [3:0]  intensity;
    logic        upd;

    logic       call_a, busy_a, initd_a, tmo_a;
    logic       done_a = 1'b0;
    logic [7:0] addr_a, data_a;
    logic       call_b, busy_b, initd_b, tmo_b;
    logic       done_b = 1'b0;
    logic [7:0] addr_b, data_b;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit withhold = 1'b0;

    max7219_ctrlmod #(
        .REFRESH_CYC (0),
        .DECODE_MODE (8'h00),
        .SCAN_LIMIT  (8'h07),
        .GAP_CYC     (2),
        .TIMEOUT_CYC (4096)
    ) dut_a (
        .CLOCK      (clk),
        .RST        (rst),
        .iDIGITS    (digits),
        .iIntensity (intensity),
        .iUpdate    (upd),
        .oCall      (call_a),
        .oADDR      (addr_a),
        .oDATA      (data_a),
        .iDone      (done_a),
        .oBusy      (busy_a),
        .oInitDone  (initd_a),
        .oTimeout   (tmo_a)
    );

    max7219_ctrlmod #(
        .REFRESH_CYC (1000),
        .DECODE_MODE (8'h00),
        .SCAN_LIMIT  (8'h07),
        .GAP_CYC     (2),
        .TIMEOUT_CYC (4096)
    ) dut_b (
        .CLOCK      (clk),
        .RST        (rst_b),
        .iDIGITS    (64'h0807060504030201),
        .iIntensity (4'h5),
        .iUpdate    (1'b0),
        .oCall      (call_b),
        .oADDR      (addr_b),
        .oDATA      (data_b),
        .iDone      (done_b),
        .oBusy      (busy_b),
        .oInitDone  (initd_b),
        .oTimeout   (tmo_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Write-module models: one-cycle iDone 20 cycles after oCall rises.
    int   cnt_a = 0, cnt_b = 0;
    logic pc_a = 1'b0, pc_b = 1'b0;
    always @(posedge clk) begin
        done_a <= 1'b0;
        if (rst || !call_a) cnt_a <= 0;
        else if (!pc_a) cnt_a <= 19;
        else if (cnt_a > 0) begin
            cnt_a <= cnt_a - 1;
            if (cnt_a == 1 && !withhold) done_a <= 1'b1;
        end
        pc_a <= call_a;
    end
    always @(posedge clk) begin
        done_b <= 1'b0;
        if (rst_b || !call_b) cnt_b <= 0;
        else if (!pc_b) cnt_b <= 19;
        else if (cnt_b > 0) begin
            cnt_b <= cnt_b - 1;
            if (cnt_b == 1) done_b <= 1'b1;
        end
        pc_b <= call_b;
    end

    // Command log for dut_a plus handshake-rule violation counters.
    logic [15:0] cmds[$];
    int          gap_viol = 0, stab_viol = 0, low_run = 100;
    logic        mc_prev = 1'b0;
    logic [15:0] cur = '0;
    always @(negedge clk) begin
        if (rst) begin
            low_run = 100;
            mc_prev = 1'b0;
        end else begin
            if (call_a && !mc_prev) begin
                cmds.push_back({addr_a, data_a});
                cur = {addr_a, data_a};
                if (low_run < 2) gap_viol++;
            end else if (call_a && ({addr_a, data_a} !== cur)) begin
                stab_viol++;
            end
            low_run = call_a ? 0 : low_run + 1;
            mc_prev = call_a;
        end
    end

    int   starts_b[$];
    int   ti_b = -1;
    logic mb_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_b) begin
            if (initd_b && ti_b < 0) ti_b = cyc;
            if (call_b && !mb_prev && addr_b == 8'h01) starts_b.push_back(cyc);
            mb_prev = call_b;
        end
    end

    task automatic pulse_update();
        @(negedge clk) upd = 1'b1;
        @(negedge clk) upd = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy_a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_call(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (call_a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_tmo(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (tmo_a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (call_a !== 1'b0) begin n_fail++; $display("FAIL rst_call: got %b expected 0", call_a); end
        n_cmp++; if (addr_a !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %h expected 00", addr_a); end
        n_cmp++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h expected 00", data_a); end
        n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b expected 1", busy_a); end
        n_cmp++; if (initd_a !== 1'b0) begin n_fail++; $display("FAIL rst_initdone: got %b expected 0", initd_a); end
        n_cmp++; if (tmo_a !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b expected 0", tmo_a); end
    endtask

    task automatic test_init();
        bit ok;
        logic [15:0] exp_init [6] = '{16'h0F00, 16'h0C00, 16'h0B07, 16'h0900, 16'h0A05, 16'h0C01};
        cmds.delete(); gap_viol = 0; stab_viol = 0;
        rst = 1'b0; rst_b = 1'b0;
        wait_idle(2000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL init_idle: got timeout expected idle"); end
        n_cmp++; if (cmds.size() !== 14) begin n_fail++; $display("FAIL init_count: got %0d expected 14", cmds.size()); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (cmds[i] !== exp_init[i]) begin n_fail++; $display("FAIL init_cmd[%0d]: got %h expected %h", i, cmds[i], exp_init[i]); end
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (cmds[6+i] !== {8'(i+1), 8'(i+1)}) begin n_fail++; $display("FAIL init_frame[%0d]: got %h expected %h", i, cmds[6+i], {8'(i+1), 8'(i+1)}); end
        end
        n_cmp++; if (initd_a !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b expected 1", initd_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL init_busy: got %b expected 0", busy_a); end
        n_cmp++; if (gap_viol !== 0) begin n_fail++; $display("FAIL init_gap: got %0d violations expected 0", gap_viol); end
        n_cmp++; if (stab_viol !== 0) begin n_fail++; $display("FAIL init_stable: got %0d violations expected 0", stab_viol); end
    endtask

    task automatic test_frame();
        bit ok;
        digits = 64'h8877665544332211;
        cmds.delete(); gap_viol = 0; stab_viol = 0;
        pulse_update();
        repeat (2) @(negedge clk);
        wait_idle(1000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL frame_idle: got timeout expected idle"); end
        n_cmp++; if (cmds.size() !== 8) begin n_fail++; $display("FAIL frame_count: got %0d expected 8", cmds.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (cmds[i] !== {8'(i+1), 8'(8'h11*(i+1))}) begin n_fail++; $display("FAIL frame_cmd[%0d]: got %h expected %h", i, cmds[i], {8'(i+1), 8'(8'h11*(i+1))}); end
        end
        n_cmp++; if (gap_viol !== 0) begin n_fail++; $display("FAIL frame_gap: got %0d violations expected 0", gap_viol); end
        n_cmp++; if (stab_viol !== 0) begin n_fail++; $display("FAIL frame_stable: got %0d violations expected 0", stab_viol); end
    endtask

    task automatic test_intensity();
        bit ok;
        intensity = 4'hA;
        cmds.delete();
        pulse_update();
        repeat (2) @(negedge clk);
        wait_idle(1000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL inten_idle: got timeout expected idle"); end
        n_cmp++; if (cmds.size() !== 9) begin n_fail++; $display("FAIL inten_count: got %0d expected 9", cmds.size()); end
        n_cmp++; if (cmds[0] !== 16'h0A0A) begin n_fail++; $display("FAIL inten_first: got %h expected 0a0a", cmds[0]); end
        n_cmp++; if (cmds[1] !== 16'h0111) begin n_fail++; $display("FAIL inten_digit1: got %h expected 0111", cmds[1]); end
        cmds.delete();
        pulse_update();
        repeat (2) @(negedge clk);
        wait_idle(1000, ok);
        n_cmp++; if (cmds.size() !== 8) begin n_fail++; $display("FAIL inten_repeat_count: got %0d expected 8", cmds.size()); end
        n_cmp++; if (cmds[0] !== 16'h0111) begin n_fail++; $display("FAIL inten_repeat_first: got %h expected 0111", cmds[0]); end
    endtask

    task automatic test_coalesce();
        bit ok1, ok2;
        digits = 64'h1122334455667788;
        cmds.delete();
        pulse_update();
        repeat (32) @(negedge clk);
        digits = 64'hA1A2A3A4A5A6A7A8;
        for (int p = 0; p < 3; p++) begin
            pulse_update();
            repeat (3) @(negedge clk);
        end
        wait_idle(1000, ok1);
        repeat (5) @(negedge clk);
        wait_idle(1000, ok2);
        repeat (300) @(negedge clk);
        n_cmp++; if ({ok1, ok2} !== 2'b11) begin n_fail++; $display("FAIL coal_idle: got %b expected 11", {ok1, ok2}); end
        n_cmp++; if (cmds.size() !== 16) begin n_fail++; $display("FAIL coal_count: got %0d expected 16", cmds.size()); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL coal_busy: got %b expected 0", busy_a); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (cmds[i] !== {8'(i+1), 8'(8'h88 - 8'h11*i)}) begin n_fail++; $display("FAIL coal_snap[%0d]: got %h expected %h", i, cmds[i], {8'(i+1), 8'(8'h88 - 8'h11*i)}); end
            n_cmp++; if (cmds[8+i] !== {8'(i+1), 8'(8'hA8 - i)}) begin n_fail++; $display("FAIL coal_second[%0d]: got %h expected %h", i, cmds[8+i], {8'(i+1), 8'(8'hA8 - i)}); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int t0, dt;
        cmds.delete();
        withhold = 1'b1;
        pulse_update();
        wait_call(100, ok);
        t0 = cyc;
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_call: got no call expected call"); end
        wait_tmo(5000, ok);
        dt = cyc - t0;
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: got none expected pulse"); end
        n_cmp++; if (dt !== 4096) begin n_fail++; $display("FAIL tmo_delay: got %0d expected 4096", dt); end
        n_cmp++; if (call_a !== 1'b0) begin n_fail++; $display("FAIL tmo_call_drop: got %b expected 0", call_a); end
        withhold = 1'b0;
        @(negedge clk);
        n_cmp++; if (tmo_a !== 1'b0) begin n_fail++; $display("FAIL tmo_width: got %b expected 0", tmo_a); end
        wait_idle(1000, ok);
        n_cmp++; if (cmds.size() !== 8) begin n_fail++; $display("FAIL tmo_count: got %0d expected 8", cmds.size()); end
        n_cmp++; if (cmds[0] !== 16'h01A8) begin n_fail++; $display("FAIL tmo_first: got %h expected 01a8", cmds[0]); end
        n_cmp++; if (cmds[1] !== 16'h02A7) begin n_fail++; $display("FAIL tmo_next: got %h expected 02a7", cmds[1]); end
        n_cmp++; if (cmds[7] !== 16'h08A1) begin n_fail++; $display("FAIL tmo_last: got %h expected 08a1", cmds[7]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        cmds.delete();
        pulse_update();
        wait_call(100, ok);
        repeat (5) @(negedge clk);
        n_cmp++; if (call_a !== 1'b1) begin n_fail++; $display("FAIL rmid_wait: got %b expected 1", call_a); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (call_a !== 1'b0) begin n_fail++; $display("FAIL rmid_call: got %b expected 0", call_a); end
        n_cmp++; if (initd_a !== 1'b0) begin n_fail++; $display("FAIL rmid_initdone: got %b expected 0", initd_a); end
        n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rmid_busy: got %b expected 1", busy_a); end
        rst = 1'b0;
        cmds.delete();
        wait_idle(2000, ok);
        n_cmp++; if (cmds.size() !== 14) begin n_fail++; $display("FAIL rmid_count: got %0d expected 14", cmds.size()); end
        n_cmp++; if (cmds[0] !== 16'h0F00) begin n_fail++; $display("FAIL rmid_first: got %h expected 0f00", cmds[0]); end
        n_cmp++; if (cmds[4] !== 16'h0A0A) begin n_fail++; $display("FAIL rmid_inten: got %h expected 0a0a", cmds[4]); end
        n_cmp++; if (cmds[13] !== 16'h08A1) begin n_fail++; $display("FAIL rmid_last: got %h expected 08a1", cmds[13]); end
    endtask

    task automatic test_no_refresh();
        cmds.delete();
        repeat (2500) @(negedge clk);
        n_cmp++; if (cmds.size() !== 0) begin n_fail++; $display("FAIL norefresh_count: got %0d expected 0", cmds.size()); end
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL norefresh_busy: got %b expected 0", busy_a); end
    endtask

    task automatic test_refresh();
        int n;
        n = starts_b.size();
        n_cmp++; if (n < 4) begin n_fail++; $display("FAIL refresh_frames: got %0d expected at least 4", n); end
        if (n >= 4) begin
            n_cmp++; if (starts_b[1] - ti_b !== 1003) begin n_fail++; $display("FAIL refresh_first: got %0d expected 1003", starts_b[1] - ti_b); end
            n_cmp++; if (starts_b[2] - starts_b[1] !== 1000) begin n_fail++; $display("FAIL refresh_period1: got %0d expected 1000", starts_b[2] - starts_b[1]); end
            n_cmp++; if (starts_b[3] - starts_b[2] !== 1000) begin n_fail++; $display("FAIL refresh_period2: got %0d expected 1000", starts_b[3] - starts_b[2]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        rst_b = 1'b1;
        upd = 1'b0;
        intensity = 4'h5;
        digits = 64'h0807060504030201;
        test_reset();
        test_init();
        test_frame();
        test_intensity();
        test_coalesce();
        test_timeout();
        test_reset_mid();
        test_no_refresh();
        test_refresh();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
